// File: rtl/rt_fragment_pkg.sv
// Shared types and constants for the fragment writer.
package rt_fragment_pkg;

    // Writer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One fragment occupies one 32-bit word of the framebuffer.
    localparam int unsigned FRAG_BYTES  = 4;
    localparam int unsigned FRAG_SHIFT  = $clog2(FRAG_BYTES);
    localparam int unsigned FRAG_DATA_W = 32;

    // Payload held per FIFO entry.
    typedef struct packed {
        logic [FRAG_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// Small synchronous FIFO with registered storage and full/empty flags.
// Push and pop in the same cycle are both honoured.
module rt_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rt_fragment_writer.sv
// Fragment stream sink: buffers one frame of fragments and writes them to a
// linear framebuffer, checking the frame length against width*height.
// Optional feature macro: RT_FRAG_CHECKSUM_EN adds a running frame checksum port.
module rt_fragment_writer
    import rt_fragment_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DIM_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [DIM_W-1:0]  image_width,
    input  logic [DIM_W-1:0]  image_height,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic              frag_last,
    input  logic [DATA_W-1:0] frag_data,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_long
`ifdef RT_FRAG_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned TOT_W = 2 * DIM_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [TOT_W-1:0]  r_total;
    logic [TOT_W-1:0]  r_in_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic              r_err_short;
    logic              r_err_long;

    logic              w_start;
    logic              w_zero_dim;
    logic [TOT_W-1:0]  w_total;
    logic [TOT_W-1:0]  w_in_next;
    logic              w_count_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_in_end;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;

    assign w_start     = start & (r_state == IDLE);
    assign w_zero_dim  = (image_width == '0) | (image_height == '0);
    assign w_total     = TOT_W'(image_width) * TOT_W'(image_height);
    assign w_in_next   = r_in_cnt + TOT_W'(1);
    assign w_count_hit = (w_in_next == r_total);
    assign w_push      = frag_valid & w_ready;
    assign w_pop       = ~w_fifo_empty & mem_gnt;
    assign w_in_end    = w_push & (frag_last | w_count_hit);

    // Decoupling buffer between the fragment stream and the memory port.
    rt_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (frag_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN waits until every buffered fragment has been granted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = w_zero_dim ? DONE : RUN;
            RUN:     if (w_in_end) w_state_nxt = DRAIN;
            DRAIN:   if (w_fifo_empty) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE:    w_busy  = 1'b0;
            RUN:     w_ready = ~w_fifo_full;
            DRAIN:   w_ready = 1'b0;
            DONE:    w_done  = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    // Frame parameters, counters and length-error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base      <= '0;
            r_total     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else if (w_start) begin
            r_base      <= fb_base;
            r_total     <= w_total;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            if (w_push) begin
                r_in_cnt <= w_in_next;
                if (frag_last && (w_in_next < r_total)) begin
                    r_err_short <= 1'b1;
                end
                if (!frag_last && w_count_hit) begin
                    r_err_long <= 1'b1;
                end
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + ADDR_W'(1);
            end
        end
    end

`ifdef RT_FRAG_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Modular sum of every accepted fragment of the current frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + frag_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign frag_ready = w_ready;
    assign busy       = w_busy;
    assign done       = w_done;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign mem_req    = ~w_fifo_empty;
    assign mem_wdata  = w_fifo_head;
    assign mem_addr   = r_base + (r_out_cnt << FRAG_SHIFT);

endmodule

// File: tb/tb_rt_fragment_writer.sv
// Self-checking bench for rt_fragment_writer with a frame-level reference model.
module tb_rt_fragment_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] fb_base;
    logic [15:0] image_width;
    logic [15:0] image_height;
    logic        frag_valid;
    logic        frag_ready;
    logic        frag_last;
    logic [31:0] frag_data;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_long;
`ifdef RT_FRAG_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int gnt_mode = 0;

    // Monitor records
    logic [31:0] acc_data[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cycles = 0;
    int          stab_cmp = 0;
    int          stab_bad = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] p_addr;
    logic [31:0] p_data;

    logic [31:0] sent [0:63];

    rt_fragment_writer #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .DIM_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .fb_base      (fb_base),
        .image_width  (image_width),
        .image_height (image_height),
        .frag_valid   (frag_valid),
        .frag_ready   (frag_ready),
        .frag_last    (frag_last),
        .frag_data    (frag_data),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err_short    (err_short),
        .err_long     (err_long)
`ifdef RT_FRAG_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Grant pattern: 0 = always, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        mem_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Observe transfers on the opposite edge; also watch request stability while stalled
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (frag_valid && frag_ready) acc_data.push_back(frag_data);
            if (mem_req && mem_gnt) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            if (done) done_cycles++;
            if (prev_stall) begin
                stab_cmp++;
                if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_wdata !== p_data) begin
                    stab_bad++;
                    $display("FAIL req_stable: got req=%b addr=%h data=%h expected req=1 addr=%h data=%h",
                             mem_req, mem_addr, mem_wdata, p_addr, p_data);
                end
            end
            prev_stall = mem_req && !mem_gnt;
            p_addr     = mem_addr;
            p_data     = mem_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h);
        @(posedge clk); #1;
        fb_base      = base;
        image_width  = w;
        image_height = h;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    // Offer sent[0..n-1] in order until n are accepted or the cycle budget runs out
    task automatic drive_frags(input int n, input int last_idx, input bit rnd, input int max_cyc);
        int i   = 0;
        int cyc = 0;
        while (i < n && cyc < max_cyc) begin
            @(posedge clk); #1;
            frag_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            frag_data  = sent[i];
            frag_last  = (i == last_idx);
            @(negedge clk);
            if (frag_valid && frag_ready) i++;
            cyc++;
        end
        @(posedge clk); #1;
        frag_valid = 1'b0;
        frag_last  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        int c = 0;
        @(negedge clk);
        while (busy && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        timed_out = busy;
    endtask

    // Full frame scenario checked against the length/addressing rules
    task automatic run_frame(input string nm, input logic [31:0] base, input int w, input int h,
                             input int n, input int last_idx, input bit rnd, input int gmode);
        int a0, w0, d0, total, exp_n;
        bit exp_s, exp_l, to;
        logic [31:0] sum, ea;
        a0 = acc_data.size();
        w0 = wr_addr.size();
        d0 = done_cycles;
        gnt_mode = gmode;
        start_frame(base, 16'(w), 16'(h));
        drive_frags(n, last_idx, rnd, 8 * n + 40);
        wait_idle(300, to);
        gnt_mode = 0;

        total = w * h;
        exp_s = (total > 0) && (last_idx >= 0) && (last_idx + 1 < total);
        exp_l = (total > 0) && !((last_idx >= 0) && (last_idx < total));
        exp_n = (total == 0) ? 0 : (exp_s ? last_idx + 1 : total);

        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s idle_timeout: got busy=1 expected busy=0", nm);
        end
        n_cmp++;
        if (acc_data.size() - a0 != exp_n) begin
            n_bad++;
            $display("FAIL %s accepted: got %0d expected %0d", nm, acc_data.size() - a0, exp_n);
        end
        n_cmp++;
        if (wr_addr.size() - w0 != exp_n) begin
            n_bad++;
            $display("FAIL %s writes: got %0d expected %0d", nm, wr_addr.size() - w0, exp_n);
        end
        sum = '0;
        for (int i = 0; i < exp_n; i++) begin
            ea  = base + 32'(4 * i);
            sum = sum + sent[i];
            if (w0 + i < wr_addr.size()) begin
                n_cmp++;
                if (wr_addr[w0 + i] !== ea || wr_data[w0 + i] !== sent[i]) begin
                    n_bad++;
                    $display("FAIL %s write[%0d]: got %h<=%h expected %h<=%h",
                             nm, i, wr_addr[w0 + i], wr_data[w0 + i], ea, sent[i]);
                end
            end
        end
        n_cmp++;
        if (err_short !== exp_s || err_long !== exp_l) begin
            n_bad++;
            $display("FAIL %s errs: got short=%b long=%b expected short=%b long=%b",
                     nm, err_short, err_long, exp_s, exp_l);
        end
        n_cmp++;
        if (done_cycles - d0 != 1) begin
            n_bad++;
            $display("FAIL %s done_cycles: got %0d expected 1", nm, done_cycles - d0);
        end
`ifdef RT_FRAG_CHECKSUM_EN
        n_cmp++;
        if (checksum !== sum) begin
            n_bad++;
            $display("FAIL %s checksum: got %h expected %h", nm, checksum, sum);
        end
`else
        if (sum === 32'hx) $display("note: undefined fragment data in %s", nm);
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; frag_valid = 1'b0; frag_last = 1'b0;
        frag_data = '0; fb_base = '0; image_width = '0; image_height = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({frag_ready, mem_req, busy, done, err_short, err_long} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy=%b req=%b busy=%b done=%b es=%b el=%b expected all 0",
                     frag_ready, mem_req, busy, done, err_short, err_long);
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0/0", mem_addr, mem_wdata);
        end
`ifdef RT_FRAG_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_checksum: got %h expected 0", checksum);
        end
`endif
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || frag_ready !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got busy=%b rdy=%b req=%b expected 0/0/0", busy, frag_ready, mem_req);
        end
    endtask

    task automatic test_basic();
        int w, h, tot, last;
        sent[0] = 32'hA; sent[1] = 32'hB; sent[2] = 32'hC; sent[3] = 32'hD;
        run_frame("basic_2x2", 32'h1000, 2, 2, 4, 3, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            w    = $urandom_range(1, 3);
            h    = $urandom_range(1, 3);
            tot  = w * h;
            last = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, tot + 1));
            for (int i = 0; i < tot + 2; i++) sent[i] = $urandom;
            run_frame("random_frame", (k == 0) ? 32'hFFFF_FFF8 : $urandom & 32'hFFFF_FFFC,
                      w, h, tot + 2, last, 1'b1, 1);
        end
    endtask

    task automatic test_backpressure();
        int a0, w0, d0;
        bit to;
        for (int i = 0; i < 8; i++) sent[i] = $urandom;
        a0 = acc_data.size(); w0 = wr_addr.size(); d0 = done_cycles;
        gnt_mode = 2;
        start_frame(32'h2000_0000, 16'd2, 16'd4);
        fork
            drive_frags(8, 7, 1'b0, 200);
            begin
                repeat (20) @(negedge clk);
                n_cmp++;
                if (acc_data.size() - a0 != 4 || frag_ready !== 1'b0 || wr_addr.size() - w0 != 0) begin
                    n_bad++;
                    $display("FAIL bp_stall: got acc=%0d rdy=%b wr=%0d expected acc=4 rdy=0 wr=0",
                             acc_data.size() - a0, frag_ready, wr_addr.size() - w0);
                end
                gnt_mode = 1;
            end
        join
        wait_idle(300, to);
        gnt_mode = 0;
        n_cmp++;
        if (to || wr_addr.size() - w0 != 8) begin
            n_bad++;
            $display("FAIL bp_writes: got %0d (timeout=%b) expected 8", wr_addr.size() - w0, to);
        end
        for (int i = 0; i < 8 && w0 + i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[w0 + i] !== 32'h2000_0000 + 32'(4 * i) || wr_data[w0 + i] !== sent[i]) begin
                n_bad++;
                $display("FAIL bp_write[%0d]: got %h<=%h expected %h<=%h", i, wr_addr[w0 + i],
                         wr_data[w0 + i], 32'h2000_0000 + 32'(4 * i), sent[i]);
            end
        end
        n_cmp++;
        if (err_short !== 1'b0 || err_long !== 1'b0 || done_cycles - d0 != 1) begin
            n_bad++;
            $display("FAIL bp_end: got es=%b el=%b done=%0d expected 0/0/1",
                     err_short, err_long, done_cycles - d0);
        end
    endtask

    task automatic test_short();
        for (int i = 0; i < 4; i++) sent[i] = $urandom;
        run_frame("short", 32'h0000_3000, 2, 2, 4, 1, 1'b1, 0);
    endtask

    task automatic test_long();
        for (int i = 0; i < 6; i++) sent[i] = $urandom;
        run_frame("long", 32'h0000_4000, 2, 2, 6, -1, 1'b1, 1);
        n_cmp++;
        if (frag_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL long_ready_after: got %b expected 0", frag_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int a0, d0;
        for (int i = 0; i < 4; i++) sent[i] = $urandom;
        a0 = acc_data.size(); d0 = done_cycles;
        gnt_mode = 2;
        start_frame(32'h5000, 16'd2, 16'd2);
        drive_frags(3, -1, 1'b0, 40);
        n_cmp++;
        if (acc_data.size() - a0 != 3 || mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got acc=%0d req=%b expected 3/1", acc_data.size() - a0, mem_req);
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || frag_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got req=%b rdy=%b busy=%b expected 0/0/0", mem_req, frag_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        resetn   = 1'b1;
        gnt_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cycles - d0 != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_done: got done=%0d busy=%b expected 0/0", done_cycles - d0, busy);
        end
        sent[0] = $urandom;
        run_frame("after_reset_1x1", 32'h6000, 1, 1, 1, 0, 1'b0, 0);
    endtask

    task automatic test_zero_size();
        int a0, w0, d0, c;
        a0 = acc_data.size(); w0 = wr_addr.size(); d0 = done_cycles;
        start_frame(32'h7000, 16'd0, 16'd5);
        frag_valid = 1'b1; frag_data = 32'h1234_5678;
        c = 0;
        @(negedge clk);
        while (!done && c < 4) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done: got done=%b within %0d cycles expected 1", done, c);
        end
        repeat (3) @(negedge clk);
        frag_valid = 1'b0;
        n_cmp++;
        if (acc_data.size() - a0 != 0 || wr_addr.size() - w0 != 0 || done_cycles - d0 != 1) begin
            n_bad++;
            $display("FAIL zero_traffic: got acc=%0d wr=%0d done=%0d expected 0/0/1",
                     acc_data.size() - a0, wr_addr.size() - w0, done_cycles - d0);
        end
        n_cmp++;
        if (err_short !== 1'b0 || err_long !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_flags: got es=%b el=%b busy=%b expected 0/0/0", err_short, err_long, busy);
        end
    endtask

`ifdef RT_FRAG_CHECKSUM_EN
    task automatic test_checksum();
        sent[0] = 32'hFFFF_FFFF;
        sent[1] = 32'h0000_0002;
        run_frame("checksum", 32'h8000, 1, 2, 2, 1, 1'b0, 0);
        n_cmp++;
        if (checksum !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL checksum_wrap: got %h expected 00000001", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid_frame();
        test_zero_size();
`ifdef RT_FRAG_CHECKSUM_EN
        test_checksum();
`endif
        n_cmp++;
        if (stab_bad != 0) begin
            n_bad++;
            $display("FAIL req_stability: got %0d unstable of %0d stalls expected 0", stab_bad, stab_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
